// File: rtl/ipsxb_fft_stream_mon.sv
// ipsxb_fft_stream_mon
//   Runtime-configurable checker for the FFT core AXI4-Stream output. Over a
//   programmable number of frames it checks the index sequence (natural or
//   bit-reversed), tlast placement, block-exponent range and frame count.
//   Errors are held in sticky per-class flags, the first error is captured,
//   and a watchdog ends a stalled test.
//
//   Optional feature: define IPSXB_FFT_MON_ERR_CNT_EN to add o_err_cnt, a
//   saturating count of cycles in which any check fired.
//
// Ports
//   i_aclk, i_areset (sync, active high), i_aclken (clock enable)
//   i_axi4s_data_*   : monitored output stream (tdata is not checked)
//   i_cfg_logs_len   : log2 point size, clamped, latched on start
//   i_cfg_order      : 1 natural / 0 bit-reversed, latched on start
//   i_cfg_frame_num  : frames expected (0 means 1), latched on start
//   i_start_test     : start / restart pulse
//   i_abort          : force DONE (frame error if count short)
//   o_busy, o_chk_finished, o_err, o_err_flags[4:0]
//     flags: [0] index, [1] tlast missing, [2] tlast unexpected,
//            [3] frame count, [4] blk_exp range
//   o_frm_cnt, o_first_err_frm, o_first_err_idx
module ipsxb_fft_stream_mon #(
    parameter int unsigned MAX_LOGS_FFT_LEN = 12,
    parameter int unsigned MIN_LOGS_FFT_LEN = 3,
    parameter int unsigned INPUT_WIDTH      = 16,
    parameter int unsigned SCALE_MODE       = 0,
    parameter int unsigned FRM_CNT_WIDTH    = 16,
    parameter int unsigned TIMEOUT_WIDTH    = 24,
    localparam int unsigned OUTPUT_WIDTH    = (SCALE_MODE != 0) ? INPUT_WIDTH
                                              : INPUT_WIDTH + MAX_LOGS_FFT_LEN + 1,
    localparam int unsigned DATAOUT_WIDTH   = ((OUTPUT_WIDTH + 7) / 8) * 8,
    localparam int unsigned USER_WIDTH      = 8 * ((MAX_LOGS_FFT_LEN + 7) / 8 + 1)
) (
    input  logic                          i_aclk,
    input  logic                          i_areset,
    input  logic                          i_aclken,
    input  logic                          i_axi4s_data_tvalid,
    input  logic [2*DATAOUT_WIDTH-1:0]    i_axi4s_data_tdata,
    input  logic                          i_axi4s_data_tlast,
    input  logic [USER_WIDTH-1:0]         i_axi4s_data_tuser,
    input  logic [4:0]                    i_cfg_logs_len,
    input  logic                          i_cfg_order,
    input  logic [FRM_CNT_WIDTH-1:0]      i_cfg_frame_num,
    input  logic                          i_start_test,
    input  logic                          i_abort,
    output logic                          o_busy,
    output logic                          o_chk_finished,
    output logic                          o_err,
    output logic [4:0]                    o_err_flags,
    output logic [FRM_CNT_WIDTH-1:0]      o_frm_cnt,
    output logic [FRM_CNT_WIDTH-1:0]      o_first_err_frm,
    output logic [MAX_LOGS_FFT_LEN-1:0]   o_first_err_idx
`ifdef IPSXB_FFT_MON_ERR_CNT_EN
    ,
    output logic [15:0]                   o_err_cnt
`endif
);

    localparam int unsigned IDX_W    = MAX_LOGS_FFT_LEN;
    localparam int unsigned LEN_W    = 5;
    localparam int unsigned FLG_W    = 5;
    localparam int unsigned BEXP_MSB = USER_WIDTH - 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic                       ord_q, ord_d;
    logic [FRM_CNT_WIDTH-1:0]   tgt_q, tgt_d;
    logic [IDX_W-1:0]           cnt_q, cnt_d;
    logic [FRM_CNT_WIDTH-1:0]   frm_q, frm_d;
    logic [TIMEOUT_WIDTH-1:0]   wd_q, wd_d;
    logic [FLG_W-1:0]           flags_q, flags_d;
    logic [FRM_CNT_WIDTH-1:0]   ferr_frm_q, ferr_frm_d;
    logic [IDX_W-1:0]           ferr_idx_q, ferr_idx_d;
    logic                       busy_q, busy_d;
    logic                       fin_q, fin_d;
    logic                       err_q, err_d;

    logic [FLG_W-1:0]           hits_c;
    logic [LEN_W-1:0]           len_clamp_c;
    logic [LEN_W-1:0]           shamt_c;
    logic [IDX_W-1:0]           cnt_max_c;
    logic [IDX_W-1:0]           rev_full_c;
    logic [IDX_W-1:0]           exp_idx_c;
    logic [4:0]                 blk_exp_c;
    logic                       blk_bad_c;
    logic                       beat_c;
    logic                       at_last_c;
    logic                       unused_c;

    // tdata and the spare tuser bits carry nothing the checker looks at
    assign unused_c = ^{i_axi4s_data_tdata, i_axi4s_data_tuser};

    // Configured point size clamped to the supported range
    always_comb begin
        len_clamp_c = i_cfg_logs_len;
        if (i_cfg_logs_len < LEN_W'(MIN_LOGS_FFT_LEN)) begin
            len_clamp_c = LEN_W'(MIN_LOGS_FFT_LEN);
        end else if (i_cfg_logs_len > LEN_W'(MAX_LOGS_FFT_LEN)) begin
            len_clamp_c = LEN_W'(MAX_LOGS_FFT_LEN);
        end
    end

    // Expected index: reversing the full counter then shifting down by the
    // unused width gives the reverse of the low L bits with upper bits zero.
    assign shamt_c    = LEN_W'(MAX_LOGS_FFT_LEN) - len_q;
    assign cnt_max_c  = {IDX_W{1'b1}} >> shamt_c;
    assign rev_full_c = {<<{cnt_q}};
    assign exp_idx_c  = ord_q ? cnt_q : (rev_full_c >> shamt_c);

    assign beat_c    = i_axi4s_data_tvalid;
    assign at_last_c = (cnt_q == cnt_max_c);
    assign blk_exp_c = i_axi4s_data_tuser[BEXP_MSB -: 5];
    assign blk_bad_c = (SCALE_MODE != 0) ? (blk_exp_c > len_q) : (blk_exp_c != 5'd0);

`ifdef IPSXB_FFT_MON_ERR_CNT_EN
    logic [15:0] ecnt_q, ecnt_d;
`endif

    // Next-state, checks and captures
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ord_d      = ord_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        frm_d      = frm_q;
        wd_d       = wd_q;
        flags_d    = flags_q;
        ferr_frm_d = ferr_frm_q;
        ferr_idx_d = ferr_idx_q;
        hits_c     = '0;
`ifdef IPSXB_FFT_MON_ERR_CNT_EN
        ecnt_d     = ecnt_q;
`endif
        if (i_aclken) begin
            if (i_start_test) begin
                // start wins over a coincident beat
                state_d    = S_RUN;
                len_d      = len_clamp_c;
                ord_d      = i_cfg_order;
                tgt_d      = (i_cfg_frame_num == '0) ? FRM_CNT_WIDTH'(1) : i_cfg_frame_num;
                cnt_d      = '0;
                frm_d      = '0;
                wd_d       = '0;
                flags_d    = '0;
                ferr_frm_d = '0;
                ferr_idx_d = '0;
`ifdef IPSXB_FFT_MON_ERR_CNT_EN
                ecnt_d     = '0;
`endif
            end else begin
                case (state_q)
                    S_RUN: begin
                        hits_c[0] = beat_c && (i_axi4s_data_tuser[IDX_W-1:0] != exp_idx_c);
                        hits_c[1] = beat_c && at_last_c && !i_axi4s_data_tlast;
                        hits_c[2] = i_axi4s_data_tlast && (!beat_c || !at_last_c);
                        hits_c[4] = beat_c && blk_bad_c;
                        if (beat_c) begin
                            wd_d = '0;
                            // frame closes on tlast or on the last position
                            if (i_axi4s_data_tlast || at_last_c) begin
                                cnt_d = '0;
                                if (frm_q != '1) begin
                                    frm_d = frm_q + FRM_CNT_WIDTH'(1);
                                end
                            end else begin
                                cnt_d = cnt_q + IDX_W'(1);
                            end
                        end else begin
                            wd_d = wd_q + TIMEOUT_WIDTH'(1);
                        end
                        if ((frm_d >= tgt_q) || i_abort || (wd_d == '1)) begin
                            state_d   = S_DONE;
                            hits_c[3] = (frm_d < tgt_q);
                        end
                    end
                    S_DONE: begin
                        hits_c[3] = beat_c;
                    end
                    // IDLE is only reachable from reset, so no test has run yet
                    default: begin
                    end
                endcase
                flags_d = flags_q | hits_c;
                if ((flags_q == '0) && (hits_c != '0)) begin
                    ferr_frm_d = frm_q;
                    ferr_idx_d = cnt_q;
                end
`ifdef IPSXB_FFT_MON_ERR_CNT_EN
                if ((hits_c != '0) && (ecnt_q != 16'hFFFF)) begin
                    ecnt_d = ecnt_q + 16'd1;
                end
`endif
            end
        end
        busy_d = (state_d == S_RUN);
        fin_d  = (state_d != S_RUN);
        err_d  = |flags_d;
    end

    // State and output registers
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state_q    <= S_IDLE;
            len_q      <= LEN_W'(MIN_LOGS_FFT_LEN);
            ord_q      <= 1'b0;
            tgt_q      <= '0;
            cnt_q      <= '0;
            frm_q      <= '0;
            wd_q       <= '0;
            flags_q    <= '0;
            ferr_frm_q <= '0;
            ferr_idx_q <= '0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ord_q      <= ord_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            frm_q      <= frm_d;
            wd_q       <= wd_d;
            flags_q    <= flags_d;
            ferr_frm_q <= ferr_frm_d;
            ferr_idx_q <= ferr_idx_d;
            busy_q     <= busy_d;
            fin_q      <= fin_d;
            err_q      <= err_d;
        end
    end

`ifdef IPSXB_FFT_MON_ERR_CNT_EN
    // Saturating check-fire counter
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end
    assign o_err_cnt = ecnt_q;
`endif

    assign o_busy          = busy_q;
    assign o_chk_finished  = fin_q;
    assign o_err           = err_q;
    assign o_err_flags     = flags_q;
    assign o_frm_cnt       = frm_q;
    assign o_first_err_frm = ferr_frm_q;
    assign o_first_err_idx = ferr_idx_q;

endmodule

// File: tb/tb_ipsxb_fft_stream_mon.sv
// Bench for ipsxb_fft_stream_mon: two instances (unscaled and block floating
// point, 8-bit watchdog) share one directed stimulus stream. A behavioural
// model per instance is compared every cycle; literal checks pin key points.
module tb_ipsxb_fft_stream_mon;

    localparam int unsigned MAXL = 12;
    localparam int unsigned FW   = 16;
    localparam int unsigned TW   = 8;
    localparam int unsigned UW   = 24;

    logic            clk = 1'b0;
    logic            rst, en, v, tl, start, abort, ord;
    logic [UW-1:0]   tuser;
    logic [4:0]      cfg_len;
    logic [FW-1:0]   fnum;
    logic [63:0]     tdata;

    logic            busy[2], fin[2], err[2];
    logic [4:0]      flags[2];
    logic [FW-1:0]   frm[2], ferr_frm[2];
    logic [MAXL-1:0] ferr_idx[2];
`ifdef IPSXB_FFT_MON_ERR_CNT_EN
    logic [15:0]     ecnt[2];
`endif

    always #5 clk = ~clk;

    // index 0: SCALE_MODE=0, index 1: SCALE_MODE=1
    ipsxb_fft_stream_mon #(.MAX_LOGS_FFT_LEN(MAXL), .MIN_LOGS_FFT_LEN(3), .INPUT_WIDTH(16),
        .SCALE_MODE(0), .FRM_CNT_WIDTH(FW), .TIMEOUT_WIDTH(TW)) dut_u (
        .i_aclk(clk), .i_areset(rst), .i_aclken(en), .i_axi4s_data_tvalid(v),
        .i_axi4s_data_tdata(tdata), .i_axi4s_data_tlast(tl), .i_axi4s_data_tuser(tuser),
        .i_cfg_logs_len(cfg_len), .i_cfg_order(ord), .i_cfg_frame_num(fnum),
        .i_start_test(start), .i_abort(abort), .o_busy(busy[0]), .o_chk_finished(fin[0]),
        .o_err(err[0]), .o_err_flags(flags[0]), .o_frm_cnt(frm[0]),
        .o_first_err_frm(ferr_frm[0]), .o_first_err_idx(ferr_idx[0])
`ifdef IPSXB_FFT_MON_ERR_CNT_EN
        , .o_err_cnt(ecnt[0])
`endif
    );

    ipsxb_fft_stream_mon #(.MAX_LOGS_FFT_LEN(MAXL), .MIN_LOGS_FFT_LEN(3), .INPUT_WIDTH(16),
        .SCALE_MODE(1), .FRM_CNT_WIDTH(FW), .TIMEOUT_WIDTH(TW)) dut_s (
        .i_aclk(clk), .i_areset(rst), .i_aclken(en), .i_axi4s_data_tvalid(v),
        .i_axi4s_data_tdata(tdata[31:0]), .i_axi4s_data_tlast(tl), .i_axi4s_data_tuser(tuser),
        .i_cfg_logs_len(cfg_len), .i_cfg_order(ord), .i_cfg_frame_num(fnum),
        .i_start_test(start), .i_abort(abort), .o_busy(busy[1]), .o_chk_finished(fin[1]),
        .o_err(err[1]), .o_err_flags(flags[1]), .o_frm_cnt(frm[1]),
        .o_first_err_frm(ferr_frm[1]), .o_first_err_idx(ferr_idx[1])
`ifdef IPSXB_FFT_MON_ERR_CNT_EN
        , .o_err_cnt(ecnt[1])
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int p, input int l);
        int r = 0;
        for (int i = 0; i < l; i++) begin
            if (((p >> i) & 1) != 0) r |= (1 << (l - 1 - i));
        end
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 running, 2 done
    int m_mode[2], m_l[2], m_nat[2], m_tgt[2], m_pos[2], m_frm[2];
    int m_idle[2], m_flags[2], m_ffrm[2], m_fidx[2], m_ecnt[2];
    bit m_ok = 1'b0;

    task automatic m_step(input int s);
        int h, pos0, frm0, idx, bexp, expi, last_pos;
        bit bad;
        if (rst) begin
            m_mode[s] = 0; m_l[s] = 3; m_nat[s] = 0; m_tgt[s] = 0; m_pos[s] = 0;
            m_frm[s] = 0; m_idle[s] = 0; m_flags[s] = 0; m_ffrm[s] = 0; m_fidx[s] = 0;
            m_ecnt[s] = 0;
            return;
        end
        if (!en) return;
        if (start) begin
            m_mode[s] = 1;
            m_l[s]    = (cfg_len < 3) ? 3 : (cfg_len > 12) ? 12 : int'(cfg_len);
            m_nat[s]  = int'(ord);
            m_tgt[s]  = (fnum == 0) ? 1 : int'(fnum);
            m_pos[s] = 0; m_frm[s] = 0; m_idle[s] = 0; m_flags[s] = 0;
            m_ffrm[s] = 0; m_fidx[s] = 0; m_ecnt[s] = 0;
            return;
        end
        h = 0; pos0 = m_pos[s]; frm0 = m_frm[s];
        idx  = int'(tuser[11:0]);
        bexp = int'(tuser[20:16]);
        if (m_mode[s] == 1) begin
            last_pos = (pos0 == (1 << m_l[s]) - 1);
            if (v) begin
                expi = (m_nat[s] != 0) ? pos0 : bitrev(pos0, m_l[s]);
                if (idx != expi) h |= 1;
                if (last_pos != 0 && !tl) h |= 2;
                bad = (s == 1) ? (bexp > m_l[s]) : (bexp != 0);
                if (bad) h |= 16;
                if (tl || last_pos != 0) begin
                    m_pos[s] = 0;
                    if (m_frm[s] < 65535) m_frm[s]++;
                end else begin
                    m_pos[s]++;
                end
                m_idle[s] = 0;
            end else begin
                m_idle[s]++;
            end
            if (tl && (!v || last_pos == 0)) h |= 4;
            if (m_frm[s] >= m_tgt[s] || abort || m_idle[s] >= 255) begin
                m_mode[s] = 2;
                if (m_frm[s] < m_tgt[s]) h |= 8;
            end
        end else if (m_mode[s] == 2 && v) begin
            h |= 8;
        end
        if (m_flags[s] == 0 && h != 0) begin
            m_ffrm[s] = frm0;
            m_fidx[s] = pos0;
        end
        m_flags[s] |= h;
        if (h != 0 && m_ecnt[s] < 65535) m_ecnt[s]++;
    endtask

    always @(posedge clk) begin
        m_step(0);
        m_step(1);
        if (rst) m_ok = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_ok) begin
            for (int s = 0; s < 2; s++) begin
                check($sformatf("busy[%0d]", s), busy[s], (m_mode[s] == 1) ? 1 : 0);
                check($sformatf("finished[%0d]", s), fin[s], (m_mode[s] != 1) ? 1 : 0);
                check($sformatf("err[%0d]", s), err[s], (m_flags[s] != 0) ? 1 : 0);
                check($sformatf("flags[%0d]", s), flags[s], m_flags[s]);
                check($sformatf("frm_cnt[%0d]", s), frm[s], m_frm[s]);
                check($sformatf("first_err_frm[%0d]", s), ferr_frm[s], m_ffrm[s]);
                check($sformatf("first_err_idx[%0d]", s), ferr_idx[s], m_fidx[s]);
`ifdef IPSXB_FFT_MON_ERR_CNT_EN
                check($sformatf("err_cnt[%0d]", s), ecnt[s], m_ecnt[s]);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [UW-1:0] mk_user(input int idx, input int bexp);
        return {3'b000, 5'(bexp), 4'b0000, 12'(idx)};
    endfunction

    task automatic do_start(input int l, input int o, input int f);
        cfg_len = 5'(l); ord = o[0]; fnum = FW'(f);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_frame(input int l, input int nat, input int n, input int last_at,
                              input int bad_at, input int bexp);
        int idx;
        for (int b = 0; b < n; b++) begin
            idx = (nat != 0) ? b : bitrev(b, l);
            if (b == bad_at) idx ^= 1;
            v = 1'b1; tl = (b == last_at); tuser = mk_user(idx, bexp);
            tdata = {$urandom, $urandom};
            tick();
        end
        v = 1'b0; tl = 1'b0; tuser = '0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; v = 1'b0; tl = 1'b0; start = 1'b0; abort = 1'b0;
        ord = 1'b1; tuser = '0; cfg_len = 5'd4; fnum = '0; tdata = '0;
        tick(); tick();
        check("reset busy", busy[1], 0);
        check("reset finished", fin[1], 1);
        check("reset flags", flags[1], 0);
        check("reset frm_cnt", frm[1], 0);
        rst = 1'b0;
        tick();

        // three clean natural 16-point frames
        do_start(4, 1, 3);
        for (int k = 0; k < 3; k++) send_frame(4, 1, 16, 15, -1, 0);
        check("clean busy", busy[1], 0);
        check("clean frm_cnt", frm[1], 3);
        check("clean err", err[1], 0);

        // bit-reversed, second frame corrupted at beat 2
        do_start(5, 0, 2);
        send_frame(5, 0, 32, 31, -1, 0);
        send_frame(5, 0, 32, 31, 2, 0);
        check("bitrev flags", flags[1], 1);
        check("bitrev first_err_frm", ferr_frm[1], 1);
        check("bitrev first_err_idx", ferr_idx[1], 2);

        // early tlast on beat 9 of frame 1, then resync
        do_start(4, 1, 3);
        send_frame(4, 1, 16, 15, -1, 0);
        send_frame(4, 1, 10, 9, -1, 0);
        send_frame(4, 1, 16, 15, -1, 0);
        check("early tlast flags", flags[1], 4);
        check("early tlast frm_cnt", frm[1], 3);
        check("early tlast first_err_idx", ferr_idx[1], 9);

        // missing tlast
        do_start(4, 1, 1);
        send_frame(4, 1, 16, -1, -1, 0);
        check("missing tlast flags", flags[1], 2);
        check("missing tlast frm_cnt", frm[1], 1);

        // watchdog: 255 idle cycles after the last beat
        do_start(3, 1, 4);
        send_frame(3, 1, 8, 7, -1, 0);
        repeat (254) tick();
        check("timeout not yet", busy[1], 1);
        tick();
        check("timeout busy", busy[1], 0);
        check("timeout flags", flags[1], 8);

        // blk_exp: 3 legal only when scaled, 7 > L=6 illegal for both
        do_start(6, 1, 2);
        send_frame(6, 1, 64, 63, -1, 3);
        send_frame(6, 1, 64, 63, -1, 7);
        check("blk_exp scaled flags", flags[1], 16);
        check("blk_exp scaled first_err_frm", ferr_frm[1], 1);
        check("blk_exp unscaled flags", flags[0], 16);
        check("blk_exp unscaled first_err_frm", ferr_frm[0], 0);

        // restart mid-run clears, then abort short
        do_start(4, 1, 2);
        send_frame(4, 1, 1, -1, 0, 0);
        check("pre-restart flags", flags[1], 1);
        do_start(4, 1, 2);
        check("restart flags", flags[1], 0);
        check("restart busy", busy[1], 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort flags", flags[1], 8);

        // abort together with the frame-completing beat
        do_start(3, 1, 1);
        send_frame(3, 1, 7, -1, -1, 0);
        v = 1'b1; tl = 1'b1; tuser = mk_user(7, 0); abort = 1'b1;
        tick();
        v = 1'b0; tl = 1'b0; tuser = '0; abort = 1'b0;
        check("abort+beat flags", flags[1], 0);
        check("abort+beat frm_cnt", frm[1], 1);

        // beat in DONE
        send_frame(3, 1, 1, -1, -1, 0);
        check("done beat flags", flags[1], 8);

        // start with a beat, then clock enable held low
        cfg_len = 5'd3; ord = 1'b1; fnum = FW'(1);
        v = 1'b1; tuser = mk_user(5, 0); start = 1'b1;
        tick();
        v = 1'b0; tuser = '0; start = 1'b0;
        check("start+beat flags", flags[1], 0);
        en = 1'b0; v = 1'b1; tl = 1'b1; abort = 1'b1; tuser = mk_user(3, 9);
        repeat (3) tick();
        en = 1'b1; v = 1'b0; tl = 1'b0; abort = 1'b0; tuser = '0;
        check("clken hold frm_cnt", frm[1], 0);
        check("clken hold busy", busy[1], 1);
        send_frame(3, 1, 8, 7, -1, 0);
        check("after clken frm_cnt", frm[1], 1);

        // tlast without tvalid
        do_start(3, 1, 1);
        tl = 1'b1; tick(); tl = 1'b0;
        check("tlast no valid flags", flags[1], 4);
        send_frame(3, 1, 8, 7, -1, 0);

        // clamp low with frame_num 0
        do_start(1, 1, 0);
        send_frame(3, 1, 8, 7, -1, 0);
        check("clamp low flags", flags[1], 0);
        check("clamp low frm_cnt", frm[1], 1);

        // clamp high, bit-reversed over 12 bits
        do_start(20, 0, 5);
        send_frame(12, 0, 2, -1, -1, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("clamp high flags", flags[1], 8);

        // reset mid-test
        do_start(4, 1, 2);
        send_frame(4, 1, 3, -1, 1, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid reset busy", busy[1], 0);
        check("mid reset finished", fin[1], 1);
        check("mid reset flags", flags[1], 0);
        check("mid reset first_err_idx", ferr_idx[1], 0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
